// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, default widths and the output-stage state encoding.
package noc_pkg;

   localparam int unsigned NUM_REQ       = 4;
   localparam int unsigned IDX_WIDTH     = 2;
   localparam int unsigned ADDRESS_WIDTH = 2;
   localparam int unsigned DATA_WIDTH    = 32;
   localparam int unsigned TOTAL_WIDTH   = 35;

   // Flit field positions; bits above the destination are carried untouched
   localparam int unsigned DATA_LSB   = 0;
   localparam int unsigned DEST_LSB   = DATA_WIDTH;
   localparam int unsigned RSVD_WIDTH = TOTAL_WIDTH - ADDRESS_WIDTH - DATA_WIDTH;

   typedef struct packed {
      logic [RSVD_WIDTH-1:0]    rsvd;
      logic [ADDRESS_WIDTH-1:0] dest;
      logic [DATA_WIDTH-1:0]    data;
   } flit_t;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } out_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr (modulo NumReq) wins.
module rr_arbiter #(
   parameter int unsigned NumReq   = 4,
   parameter int unsigned IdxWidth = 2
) (
   input  logic [NumReq-1:0]   req,
   input  logic [IdxWidth-1:0] ptr,
   output logic [NumReq-1:0]   grant,
   output logic [IdxWidth-1:0] grant_idx,
   output logic                grant_valid
);

   int unsigned cand;

   // Walk priority offsets from ptr; constant-index compare keeps non-power-of-2 sizes clean
   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      cand        = 0;
      for (int unsigned i = 0; i < NumReq; i++) begin
         cand = 32'(ptr) + i;
         if (cand >= NumReq) begin
            cand = cand - NumReq;
         end
         for (int unsigned j = 0; j < NumReq; j++) begin
            if (!grant_valid && (j == cand) && req[j]) begin
               grant[j]    = 1'b1;
               grant_idx   = IdxWidth'(j);
               grant_valid = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/noc_inject_arbiter.sv
// Round-robin injection arbiter feeding one router port through a registered output stage.
// Optional per-requester grant and stall counters: define NOC_INJECT_ARB_STATS_EN.
module noc_inject_arbiter
   import noc_pkg::*;
#(
   parameter int unsigned NumReq       = NUM_REQ,
   parameter int unsigned IdxWidth     = IDX_WIDTH,
   parameter int unsigned AddressWidth = ADDRESS_WIDTH,
   parameter int unsigned DataWidth    = DATA_WIDTH,
   parameter int unsigned TotalWidth   = TOTAL_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NumReq*TotalWidth-1:0] i_data,
   input  logic [NumReq-1:0]            i_data_valid,
   output logic [NumReq-1:0]            o_data_ready,
   output logic [TotalWidth-1:0]        o_data,
   output logic                         o_data_valid,
   input  logic                         i_data_ready,
   output logic [IdxWidth-1:0]          o_grant_id
`ifdef NOC_INJECT_ARB_STATS_EN
   ,
   output logic [NumReq*32-1:0]         o_grant_count,
   output logic [31:0]                  o_stall_cycles
`endif
);

   if (TotalWidth < AddressWidth + DataWidth) begin : g_bad_width
      $error("noc_inject_arbiter: TotalWidth too small for dest and data fields");
   end

   out_state_e              state_q, state_d;
   logic [TotalWidth-1:0]   data_q, data_d;
   logic [IdxWidth-1:0]     gid_q, gid_d;
   logic [IdxWidth-1:0]     ptr_q, ptr_d;

   logic [NumReq-1:0]       win;
   logic [IdxWidth-1:0]     win_idx;
   logic                    win_valid;
   logic                    can_load;
   logic                    xfer;

   rr_arbiter #(
      .NumReq   (NumReq),
      .IdxWidth (IdxWidth)
   ) u_rr_arbiter (
      .req         (i_data_valid),
      .ptr         (ptr_q),
      .grant       (win),
      .grant_idx   (win_idx),
      .grant_valid (win_valid)
   );

   // A held flit leaving this cycle frees the register for a same-edge reload
   assign can_load     = (state_q == EMPTY) | (i_data_ready & o_data_valid);
   assign o_data_ready = rst ? '0 : (win & {NumReq{can_load}});
   assign xfer         = win_valid & can_load & ~rst;

   assign o_data       = data_q;
   assign o_data_valid = (state_q == FULL);
   assign o_grant_id   = gid_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         data_q  <= '0;
         gid_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         gid_q   <= gid_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      gid_d   = gid_q;
      ptr_d   = ptr_q;
      if (xfer) begin
         state_d = FULL;
         gid_d   = win_idx;
         ptr_d   = (win_idx == IdxWidth'(NumReq - 1)) ? '0 : win_idx + IdxWidth'(1);
         for (int unsigned k = 0; k < NumReq; k++) begin
            if (win[k]) begin
               data_d = i_data[k*TotalWidth +: TotalWidth];
            end
         end
      end else if ((state_q == FULL) && i_data_ready) begin
         state_d = EMPTY;
      end
   end

`ifdef NOC_INJECT_ARB_STATS_EN
   logic [31:0] grant_cnt_q [NumReq];
   logic [31:0] stall_cnt_q;

   // Free-running counters, wrapping naturally at 2^32
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned k = 0; k < NumReq; k++) begin
            grant_cnt_q[k] <= '0;
         end
         stall_cnt_q <= '0;
      end else begin
         for (int unsigned k = 0; k < NumReq; k++) begin
            if (o_data_ready[k] & i_data_valid[k]) begin
               grant_cnt_q[k] <= grant_cnt_q[k] + 32'd1;
            end
         end
         if (o_data_valid & ~i_data_ready) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
      end
   end

   for (genvar g = 0; g < NumReq; g++) begin : g_cnt_out
      assign o_grant_count[g*32 +: 32] = grant_cnt_q[g];
   end
   assign o_stall_cycles = stall_cnt_q;
`endif

endmodule
